// File: rtl/log_memory_pkg.sv
// ============================================================================
// Module   : log_memory_pkg
// Brief    : Shared state encoding and default sizes for the capture log buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package log_memory_pkg;

  localparam int c_nb_data = 32;
  localparam int c_nb_addr = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2
  } log_state_t;

endpackage

`default_nettype wire

// File: rtl/log_ram.sv
// ============================================================================
// Module   : log_ram
// Brief    : Simple dual-port RAM, one write port and one registered read-first
//            read port, written so synthesis maps it onto block RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module log_ram #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic [NB_ADDR-1:0] i_waddr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic               i_re,
  input  logic [NB_ADDR-1:0] i_raddr,
  output logic [NB_DATA-1:0] o_rdata
);

  logic [NB_DATA-1:0] r_mem [2**NB_ADDR];
  logic [NB_DATA-1:0] r_rdata;

  // Array itself has no reset so it stays inferable as block RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read-first: a same-cycle write to raddr is not visible until the next read.
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/log_memory_ctrl.sv
// ============================================================================
// Module   : log_memory_ctrl
// Brief    : Capture-and-readback log buffer. A rising edge on i_run_log starts
//            a capture of one word per i_valid until the RAM is full; the micro
//            reads it back word by word. Optional macro LOG_DECIM_EN adds
//            i_decim to keep only every (i_decim+1)-th valid sample.
// Revision : 1.0
// ============================================================================
`default_nettype none

module log_memory_ctrl
  import log_memory_pkg::*;
#(
  parameter int NB_DATA = c_nb_data,
  parameter int NB_ADDR = c_nb_addr
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_run_log,
  input  logic               i_read_log,
  input  logic [NB_ADDR-1:0] i_addr_log,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
`ifdef LOG_DECIM_EN
  input  logic [7:0]         i_decim,
`endif
  output logic               o_mem_full,
  output logic [NB_DATA-1:0] o_data_log,
  output logic               o_capturing
);

  localparam logic [NB_ADDR-1:0] c_last_addr = '1;

  log_state_t         r_state;
  logic               r_run_d;
  logic [NB_ADDR-1:0] r_wr_addr;
  logic               r_mem_full;
  logic               r_capturing;
  logic               w_start;
  logic               w_take;
  logic               w_wr_en;

  assign w_start = i_run_log & ~r_run_d;

`ifdef LOG_DECIM_EN
  logic [7:0] r_decim;
  logic [7:0] r_decim_cnt;

  assign w_take = (r_decim_cnt == r_decim);

  // Decimation ratio is latched on start so mid-capture changes have no effect.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_decim     <= '0;
      r_decim_cnt <= '0;
    end else if (w_start) begin
      r_decim     <= i_decim;
      r_decim_cnt <= '0;
    end else if (r_state == ST_CAPTURE && i_valid) begin
      r_decim_cnt <= w_take ? 8'd0 : r_decim_cnt + 8'd1;
    end
  end
`else
  assign w_take = 1'b1;
`endif

  // A start in CAPTURE discards that cycle's sample; reset aborts any write.
  assign w_wr_en = ~reset & (r_state == ST_CAPTURE) & i_valid & ~w_start & w_take;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_run_d     <= 1'b0;
      r_wr_addr   <= '0;
      r_mem_full  <= 1'b0;
      r_capturing <= 1'b0;
    end else begin
      r_run_d <= i_run_log;
      case (r_state)
        ST_IDLE, ST_FULL: begin
          if (w_start) begin
            r_state     <= ST_CAPTURE;
            r_capturing <= 1'b1;
            r_wr_addr   <= '0;
            r_mem_full  <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (w_start) begin
            r_wr_addr <= '0;
          end else if (w_wr_en) begin
            r_wr_addr <= r_wr_addr + 1'b1;
            if (r_wr_addr == c_last_addr) begin
              r_state     <= ST_FULL;
              r_capturing <= 1'b0;
              r_mem_full  <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_capturing <= 1'b0;
        end
      endcase
    end
  end

  log_ram #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_log_ram (
    .clk     (clock),
    .rst     (reset),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_addr),
    .i_wdata (i_data),
    .i_re    (i_read_log),
    .i_raddr (i_addr_log),
    .o_rdata (o_data_log)
  );

  assign o_mem_full  = r_mem_full;
  assign o_capturing = r_capturing;

endmodule

`default_nettype wire

// File: tb/tb_log_memory_ctrl.sv
// ============================================================================
// Module   : tb_log_memory_ctrl
// Brief    : Self-checking bench for log_memory_ctrl (depth 16) against a
//            behavioural model; honours LOG_DECIM_EN when defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_log_memory_ctrl;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 4;
  localparam int DEPTH   = 16;

  logic               clock = 1'b0;
  logic               reset;
  logic               i_run_log;
  logic               i_read_log;
  logic [NB_ADDR-1:0] i_addr_log;
  logic               i_valid;
  logic [NB_DATA-1:0] i_data;
  logic [7:0]         i_decim;
  logic               o_mem_full;
  logic [NB_DATA-1:0] o_data_log;
  logic               o_capturing;

  int total = 0;
  int bad   = 0;

  log_memory_ctrl #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_run_log   (i_run_log),
    .i_read_log  (i_read_log),
    .i_addr_log  (i_addr_log),
    .i_valid     (i_valid),
    .i_data      (i_data),
`ifdef LOG_DECIM_EN
    .i_decim     (i_decim),
`endif
    .o_mem_full  (o_mem_full),
    .o_data_log  (o_data_log),
    .o_capturing (o_capturing)
  );

  always #5 clock = ~clock;

  // Model: a capture is a run of kept samples appended to RAM from address 0.
  logic [NB_DATA-1:0] m_ram [DEPTH];
  bit                 m_known [DEPTH];
  bit                 m_active, m_full, m_prev_run, m_dout_known;
  int                 m_count, m_vcount, m_dl;
  logic [NB_DATA-1:0] m_dout;

  task automatic model_update();
    bit start;
    if (reset) begin
      m_active = 0; m_full = 0; m_count = 0; m_vcount = 0;
      m_prev_run = 0; m_dout = '0; m_dout_known = 1;
      return;
    end
    start = i_run_log && !m_prev_run;
    if (i_read_log) begin
      m_dout       = m_ram[i_addr_log];
      m_dout_known = m_known[i_addr_log];
    end
    if (start) begin
      m_active = 1; m_full = 0; m_count = 0; m_vcount = 0;
`ifdef LOG_DECIM_EN
      m_dl = int'(i_decim);
`else
      m_dl = 0;
`endif
    end else if (m_active && i_valid) begin
      if ((m_vcount % (m_dl + 1)) == m_dl) begin
        m_ram[m_count]   = i_data;
        m_known[m_count] = 1;
        m_count++;
        if (m_count == DEPTH) begin
          m_active = 0; m_full = 1;
        end
      end
      m_vcount++;
    end
    m_prev_run = i_run_log;
  endtask

  task automatic check(input string tag, input logic [NB_DATA-1:0] obs, input logic [NB_DATA-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
    check("mem_full", {31'd0, o_mem_full}, {31'd0, m_full});
    check("capturing", {31'd0, o_capturing}, {31'd0, m_active});
    if (m_dout_known) check("data_log", o_data_log, m_dout);
  endtask

  task automatic drive(input bit run, input bit valid, input logic [NB_DATA-1:0] data);
    i_run_log = run; i_valid = valid; i_data = data;
    step();
  endtask

  task automatic read_at(input int addr, input logic [NB_DATA-1:0] exp, input string tag);
    i_read_log = 1; i_addr_log = NB_ADDR'(addr);
    step();
    i_read_log = 0;
    check(tag, o_data_log, exp);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    m_dl = 0;
    reset = 1; i_run_log = 0; i_read_log = 0; i_addr_log = '0;
    i_valid = 0; i_data = '0; i_decim = 8'd0;
    repeat (3) step();
    check("reset_data", o_data_log, 32'h0);
    reset = 0;

    // Idle: valids without run are ignored.
    for (int i = 0; i < 10; i++) drive(0, i[0], $urandom);
    check("idle_not_full", {31'd0, o_mem_full}, 32'd0);

    // First full capture with 0x100+n.
    drive(1, 0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, 32'h100 + i);
      if (i == DEPTH - 1) check("full_after_16", {31'd0, o_mem_full}, 32'd1);
      else                check("not_full_yet", {31'd0, o_mem_full}, 32'd0);
    end
    for (int i = 0; i < 4; i++) drive(1, 1, 32'hBAD0 + i);
    read_at(0, 32'h100, "rd0");
    read_at(5, 32'h105, "rd5");
    read_at(15, 32'h10F, "rd15");
    for (int i = 0; i < 3; i++) begin
      i_addr_log = NB_ADDR'($urandom);
      drive(1, 0, '0);
      check("hold", o_data_log, 32'h10F);
    end

    // Restart after 6 writes; the restart-cycle sample is discarded.
    drive(0, 0, '0);
    drive(1, 0, '0);
    for (int i = 0; i < 6; i++) drive(1, 1, 32'h200 + i);
    drive(0, 0, '0);
    drive(1, 1, 32'hDEAD);
    for (int i = 0; i < DEPTH - 1; i++) drive(1, 1, 32'h300 + i);
    check("restart_not_full", {31'd0, o_mem_full}, 32'd0);
    drive(1, 1, 32'h30F);
    check("restart_full", {31'd0, o_mem_full}, 32'd1);
    read_at(0, 32'h300, "restart_rd0");
    read_at(6, 32'h306, "restart_rd6");

    // Reset mid-capture, then a run held through reset starts once.
    drive(0, 0, '0);
    drive(1, 0, '0);
    for (int i = 0; i < 9; i++) drive(1, 1, 32'h900 + i);
    reset = 1;
    drive(1, 1, 32'hEEEE);
    check("rst_full", {31'd0, o_mem_full}, 32'd0);
    check("rst_capt", {31'd0, o_capturing}, 32'd0);
    check("rst_dout", o_data_log, 32'd0);
    reset = 0;
    drive(1, 0, '0);
    for (int i = 0; i < DEPTH; i++) drive(1, 1, 32'h400 + i);
    check("rerun_full", {31'd0, o_mem_full}, 32'd1);
    read_at(0, 32'h400, "rerun_rd0");
    read_at(9, 32'h409, "rerun_rd9");

`ifdef LOG_DECIM_EN
    // Decimate by 3: mem[k] gets valid number 3k+2.
    i_decim = 8'd2;
    drive(0, 0, '0);
    drive(1, 0, '0);
    for (int v = 0; v < 3 * DEPTH; v++) drive(1, 1, 32'h500 + v);
    check("decim_full", {31'd0, o_mem_full}, 32'd1);
    read_at(0, 32'h502, "decim_rd0");
    read_at(5, 32'h511, "decim_rd5");
    read_at(15, 32'h52F, "decim_rd15");
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) i_run_log = ~i_run_log;
      i_valid    = 1'($urandom);
      i_data     = $urandom;
      i_read_log = ($urandom_range(0, 2) == 0);
      i_addr_log = NB_ADDR'($urandom);
      i_decim    = 8'($urandom_range(0, 3));
      reset      = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 0; i_read_log = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/log_memory_ctrl.md
Name: log_memory_ctrl

Overview:
Capture-and-readback log buffer that sits directly downstream of file_register. It consumes o_run_log, o_read_log and o_addr_log_to_mem, and produces i_mem_full and i_data_log_from_mem. On a run request it records one word per valid sample from the datapath into an internal RAM until the RAM is full. The micro then reads the RAM word by word through file_register.

Parameters:
- NB_DATA, 32, width of a logged word; matches NB_INST of file_register.
- NB_ADDR, 15, log address width; depth = 2**NB_ADDR words.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_run_log  in  1  capture request (level from file_register); its rising edge starts a capture.
- i_read_log  in  1  read strobe from file_register.
- i_addr_log  in  NB_ADDR  read address from file_register.
- i_valid  in  1  sample strobe from the datapath; one word is written per high cycle while capturing.
- i_data  in  NB_DATA  word to log, e.g. {I sample, Q sample, flags}.
- o_mem_full  out  1  high when the buffer holds a complete capture.
- o_data_log  out  NB_DATA  read data to file_register.
- o_capturing  out  1  high while in the CAPTURE state.

Interface fixed: one clock; reset is synchronous and active-high (ports named clock and reset).

Behaviour:
- Edge detect:
  - run_d <= i_run_log; start = i_run_log & ~run_d.
  - run_d resets to 0, so a run level already high when reset releases produces exactly one start.
- FSM states: IDLE, CAPTURE, FULL (2-bit encoding).
  - IDLE: start -> CAPTURE; wr_addr <= 0; o_mem_full <= 0.
  - CAPTURE: each cycle with i_valid=1 writes mem[wr_addr] <= i_data and increments wr_addr.
  - CAPTURE: the write at wr_addr = 2**NB_ADDR-1 moves to FULL; o_mem_full <= 1 in the next cycle; wr_addr wraps to 0.
  - CAPTURE: start (a new rising edge) restarts. wr_addr <= 0 and the write of that cycle is discarded. Previously written words stay in RAM but are considered invalid.
  - FULL: no writes; i_valid is ignored; o_mem_full stays 1 until the next start, which enters CAPTURE with o_mem_full <= 0.
- Reset:
  - state=IDLE, wr_addr=0, o_mem_full=0, o_capturing=0, o_data_log=0.
  - RAM contents are not cleared.
  - Reset mid-capture aborts immediately.
- o_capturing = (state==CAPTURE), registered.
- Read path:
  - When i_read_log=1, o_data_log <= mem[i_addr_log]. Latency 1 cycle (synchronous RAM read).
  - When i_read_log=0, o_data_log holds its last value.
  - Reads are legal in any state.
  - Reading during CAPTURE returns whatever the RAM holds (old or new data); this is not an error.
- Simultaneous read and write to the same address: read returns the old data (read-first).
- i_valid while in IDLE: ignored.
- Addresses are unsigned. wr_addr is NB_ADDR bits and wraps naturally; no extra full bit is needed because FULL is encoded in the state.

Optional Feature:
- Macro LOG_DECIM_EN.
- Defined:
  - Adds input i_decim [7:0].
  - A decimation counter (reset 0, cleared on start) counts i_valid pulses in CAPTURE.
  - Only every (i_decim+1)-th valid is written, so i_decim=0 is equivalent to no decimation.
  - i_decim is sampled on start and held for the whole capture.
- Undefined: the port and counter are absent; every i_valid is written.

Decomposition:
- Package log_memory_pkg:
  - state enum/localparams ST_IDLE=2'd0, ST_CAPTURE=2'd1, ST_FULL=2'd2;
  - default NB_ADDR and NB_DATA constants.
- Sub-module log_ram:
  - simple dual-port, one write port, one synchronous read port, read-first;
  - parameterised NB_DATA and NB_ADDR;
  - written so synthesis infers BRAM.

Test Plan (simulation uses NB_ADDR=4, depth 16):
- Reset, then hold i_run_log=0 and pulse i_valid for 10 cycles -> no writes, o_mem_full=0, state IDLE.
- Rise i_run_log, drive i_valid=1 continuously with i_data=0x100+n -> o_capturing for 16 writes; o_mem_full=1 on the cycle after the 16th write; further valids are ignored.
- After full: pulse i_read_log with addr 0, 5, 15 -> o_data_log = 0x100, 0x105, 0x10F one cycle later; output holds when i_read_log=0.
- Restart after 6 writes (second run rising edge) -> o_mem_full stays 0; the next write lands at addr 0; the buffer fills after 16 more valids.
- Assert reset after 9 writes -> all outputs return to reset values; a subsequent run restarts at addr 0.
- With LOG_DECIM_EN and i_decim=2 -> 48 valids fill 16 words; mem[k] = data of valid 3k+2 (the 3rd, 6th, ... valid).
